mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences and shares the single memory port of the multicycle CPU between two requesters: instruction fetch (IF) and data load/store (D).
The block latches the winning request and drives the memory address, write data and write strobe.
It waits out the fixed memory read latency, then returns read data to the owner with a one-cycle completion pulse.
The control unit handshakes with this block instead of counting memory wait states itself.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LATENCY, 2, cycles from address presented to mem_rdata valid (legal range 1..7)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request (level, held until if_done)
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_done  out  1  one-cycle pulse: fetch data valid on if_rdata
if_rdata  out  DATA_W  fetch read data, held until next fetch completes
d_req  in  1  data request (level, held until d_done)
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse: load data valid or store committed
d_rdata  out  DATA_W  load data, held until next load completes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  memory write strobe (memWriteOrRead: 1 write, 0 read)
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs 0, including both rdata registers, mem_addr and mem_wdata.
  - last_owner = D, so IF wins the first conflict.
  - A reset that arrives mid-transaction drops mem_wr immediately; a store is never replayed after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Nothing pending: stay in IDLE.
  - Only one req high: that requester wins.
  - Both req high: grant the requester opposite to last_owner (round-robin).
  - On winning, latch owner, addr, we (IF always reads), wdata; go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_wr = 1 only for a D store; mem_wr is never high in any other state.
  - Store: go to RESP.
  - Load/fetch: load the latency counter with READ_LATENCY-1.
    - Go to RESP if READ_LATENCY = 1, else go to WAIT.
- WAIT:
  - mem_addr is held; mem_wr = 0.
  - Counter decrements each cycle; go to RESP when it reaches 1.
- RESP:
  - mem_addr is still held.
  - Reads: mem_rdata is sampled at the end of this cycle into if_rdata or d_rdata, chosen by owner.
  - The matching done pulses in the next cycle, together with the new rdata; that cycle is IDLE.
  - Update last_owner = owner; go to IDLE.
- Latency: a request seen in IDLE at cycle 0 gives done at cycle READ_LATENCY+2 for reads and at cycle 3 for stores. The store done is the registered RESP exit.
- Back-to-back: the IDLE cycle that carries done also arbitrates. A requester that keeps req high after its done pulse is treated as issuing a new transaction.
- Requests are sampled only in IDLE. Changes to addr/wdata after the latch are ignored.
- A req dropped before done is a protocol violation; the latched transaction still completes.
- rdata of the non-owner never changes.
- done pulses are exactly one cycle and never overlap (if_done and d_done mutually exclusive).

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - owner_t enum {OWN_IF, OWN_D}.
  - constant LAT_W = 3.
- One sub-module, mem_lat_counter: loadable down-counter with load value, decrement and a last flag. Asynchronous active-low reset.

Test Plan:
- Reset, then a single fetch, if_addr=0x0000_0040, mem returns 0x8C22_0004 → mem_wr stays 0, if_done pulses at cycle 4, if_rdata=0x8C22_0004, d_done stays 0.
- Single store, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF → mem_wr=1 for exactly one cycle with those values on mem_addr/mem_wdata, d_done at cycle 3, d_rdata unchanged at 0.
- if_req and d_req both raised at cycle 0, held → IF granted first (last_owner reset = D). D is granted in the IDLE cycle carrying if_done, and the grants then alternate IF, D, IF, D.
- READ_LATENCY=1 build with a load from 0x0000_0200 → WAIT is skipped and d_done arrives at cycle 3. READ_LATENCY=4 build → d_done at cycle 6.
- Reset asserted in the ISSUE cycle of a store → mem_wr falls within that cycle and outputs clear. After release with d_req still high, the store issues once and exactly one d_done follows.
- if_addr changed from 0x40 to 0x80 during WAIT → mem_addr stays 0x40 until RESP exits.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner, latency counter width.
// Pure declarations; no timing and no flow control of its own.
package mem_arb_pkg;

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter for memory read latency; last is high while the count equals 1.
// Latency: load/decrement take effect on the next edge; no backpressure.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign last = (count == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data with round-robin on conflict; reads finish at
// READ_LATENCY+2, stores at 3 cycles; requesters are level-held until their one-cycle done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  arb_state_t state_q, state_d;
  owner_t     owner_q, last_owner_q;
  logic       we_q;
  logic       grant, pick_d;
  logic       cnt_load, cnt_dec, cnt_last;

  // D wins when it is alone, or on a conflict when IF owned the port last.
  assign pick_d = d_req && (!if_req || (last_owner_q == OWN_IF));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_D;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (grant) begin
        owner_q   <= pick_d ? OWN_D : OWN_IF;
        we_q      <= pick_d && d_we;
        mem_addr  <= pick_d ? d_addr : if_addr;
        mem_wdata <= pick_d ? d_wdata : '0;
      end
      // Completion is registered so done and the new rdata appear together in the following IDLE cycle.
      if (state_q == RESP) begin
        last_owner_q <= owner_q;
        if (owner_q == OWN_IF) begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          d_done <= 1'b1;
          if (!we_q) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  // Combinational from state so an asynchronous reset drops the strobe immediately.
  assign mem_wr = (state_q == ISSUE) && we_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three builds (READ_LATENCY 2, 1, 4) sharing clock and reset,
// each backed by a memory model that returns addr ^ K exactly READ_LATENCY cycles after issue.
module tb_mem_port_arbiter;

  localparam logic [31:0] K   = 32'h8C22_0044;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        if_req [3], d_req [3], d_we [3];
  logic [31:0] if_addr [3], d_addr [3], d_wdata [3];
  logic [31:0] if_rdata [3], d_rdata [3], mem_addr [3], mem_wdata [3], mem_rdata [3];
  logic        if_done [3], d_done [3], mem_wr [3], busy [3];

  int   cyc = 0;
  int   iss [3];
  logic busy_p [3];
  int   n_tests = 0;
  int   n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .READ_LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_done   (if_done[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_done    (d_done[g]),
      .d_rdata   (d_rdata[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wr    (mem_wr[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  function automatic int rl_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // The first busy cycle after idle is the issue cycle; data is only valid READ_LATENCY cycles later.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (busy[u] === 1'b1 && busy_p[u] !== 1'b1) iss[u] = cyc;
      busy_p[u] = busy[u];
      mem_rdata[u] = (busy[u] === 1'b1 && cyc == iss[u] + rl_of(u)) ? (mem_addr[u] ^ K) : BAD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Raises the request(s) in the current IDLE cycle (cycle 0) and runs until the first done pulse.
  task automatic run_txn(input int u, input bit use_if, input bit use_d, input bit chg_addr,
                         output int dcyc, output int wr_cnt, output logic [31:0] wr_addr,
                         output logic [31:0] wr_data, output int hold_err, output int other);
    logic [31:0] exp_a;
    exp_a    = use_if ? if_addr[u] : d_addr[u];
    dcyc     = -1;
    wr_cnt   = 0;
    wr_addr  = '0;
    wr_data  = '0;
    hold_err = 0;
    other    = 0;
    if_req[u] = use_if;
    d_req[u]  = use_d;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (chg_addr && n == 2) if_addr[u] = 32'h0000_0080;
      if (mem_wr[u] === 1'b1) begin
        wr_cnt++;
        wr_addr = mem_addr[u];
        wr_data = mem_wdata[u];
      end
      if (busy[u] === 1'b1 && mem_addr[u] !== exp_a) hold_err++;
      if ((use_if && d_done[u] === 1'b1) || (use_d && if_done[u] === 1'b1)) other++;
      if ((use_if && if_done[u] === 1'b1) || (use_d && d_done[u] === 1'b1)) begin
        dcyc = n;
        if_req[u] = 1'b0;
        d_req[u]  = 1'b0;
        break;
      end
    end
    if_req[u] = 1'b0;
    d_req[u]  = 1'b0;
  endtask

  initial begin
    int          dcyc, wr_cnt, hold_err, other, k, last, ovl, extra;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  seq;

    for (int u = 0; u < 3; u++) begin
      if_req[u] = 0; d_req[u] = 0; d_we[u] = 0;
      if_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0;
      mem_rdata[u] = BAD; iss[u] = -100; busy_p[u] = 1'b0;
    end

    repeat (3) tick();
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr[0]}, 32'd0);
    chk("rst_if_done", {31'd0, if_done[0]}, 32'd0);
    chk("rst_d_done", {31'd0, d_done[0]}, 32'd0);
    chk("rst_if_rdata", if_rdata[0], 32'd0);
    chk("rst_d_rdata", d_rdata[0], 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'd0);
    chk("rst_mem_wdata", mem_wdata[0], 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Single fetch
    if_addr[0] = 32'h0000_0040;
    run_txn(0, 1, 0, 0, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("fetch_lat", dcyc, 4);
    chk("fetch_wr", wr_cnt, 0);
    chk("fetch_rdata", if_rdata[0], 32'h8C22_0004);
    chk("fetch_d_done", other, 0);
    chk("fetch_addr", hold_err, 0);
    tick();
    chk("fetch_pulse", {31'd0, if_done[0]}, 32'd0);

    // Single store
    d_we[0] = 1'b1; d_addr[0] = 32'h0000_0100; d_wdata[0] = 32'hDEAD_BEEF;
    run_txn(0, 0, 1, 0, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("store_lat", dcyc, 3);
    chk("store_wr_cnt", wr_cnt, 1);
    chk("store_wr_addr", wr_addr, 32'h0000_0100);
    chk("store_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("store_d_rdata", d_rdata[0], 32'd0);
    chk("store_if_rdata", if_rdata[0], 32'h8C22_0004);
    tick();
    chk("store_pulse", {31'd0, d_done[0]}, 32'd0);

    // Fresh reset, then both requesters held: IF, D, IF, D, one transaction per 4 cycles
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    d_we[0] = 1'b0; d_addr[0] = 32'h0000_0300; if_addr[0] = 32'h0000_0040;
    seq = '0; k = 0; last = -1; ovl = 0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if_done[0] === 1'b1 && d_done[0] === 1'b1) ovl++;
      if (k < 4 && d_done[0] === 1'b1) begin
        seq[k] = 1'b1; k++;
      end else if (k < 4 && if_done[0] === 1'b1) begin
        seq[k] = 1'b0; k++;
      end
      if (k == 4) begin
        last = n;
        break;
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("rr_order", {28'd0, seq}, 32'h0000_000A);
    chk("rr_last_done", last, 16);
    chk("rr_overlap", ovl, 0);
    chk("rr_d_rdata", d_rdata[0], 32'h8C22_0344);
    chk("rr_if_rdata", if_rdata[0], 32'h8C22_0004);
    tick();

    // Latency builds
    d_addr[1] = 32'h0000_0200; d_addr[2] = 32'h0000_0200;
    run_txn(1, 0, 1, 0, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("rl1_lat", dcyc, 3);
    chk("rl1_rdata", d_rdata[1], 32'h8C22_0244);
    run_txn(2, 0, 1, 0, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("rl4_lat", dcyc, 6);
    chk("rl4_rdata", d_rdata[2], 32'h8C22_0244);
    tick();

    // Reset in the ISSUE cycle of a store
    d_we[0] = 1'b1; d_addr[0] = 32'h0000_0400; d_wdata[0] = 32'h1234_5678;
    d_req[0] = 1'b1;
    tick();
    chk("mid_issue_wr", {31'd0, mem_wr[0]}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_wr", {31'd0, mem_wr[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("mid_rst_addr", mem_addr[0], 32'd0);
    chk("mid_rst_wdata", mem_wdata[0], 32'd0);
    chk("mid_rst_d_rdata", d_rdata[0], 32'd0);
    @(negedge clk) reset = 1'b1;
    run_txn(0, 0, 1, 0, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("mid_lat", dcyc, 3);
    chk("mid_wr_cnt", wr_cnt, 1);
    chk("mid_wr_addr", wr_addr, 32'h0000_0400);
    chk("mid_wr_data", wr_data, 32'h1234_5678);
    extra = 0;
    repeat (6) begin
      tick();
      if (d_done[0] === 1'b1 || mem_wr[0] === 1'b1) extra++;
    end
    chk("mid_no_replay", extra, 0);

    // Fetch address changes during WAIT
    d_we[0] = 1'b0;
    if_addr[0] = 32'h0000_0040;
    run_txn(0, 1, 0, 1, dcyc, wr_cnt, wr_addr, wr_data, hold_err, other);
    chk("chg_lat", dcyc, 4);
    chk("chg_addr_hold", hold_err, 0);
    chk("chg_rdata", if_rdata[0], 32'h8C22_0004);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
